bullet_pool: RTL and testbench

//  Multi-slot player-bullet engine for Space Invaders; successor to the single-bullet block.

---
 rtl/bullet_pool.sv | 153 +++++++++++++++
 tb/tb_bullet_pool.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// -----------------------------------------------------------------------------
// bullet_pool
//   Multi-slot player-bullet engine. Up to N_BULLETS bullets are launched from
//   the ship column, climb one row per movement tick of an internal prescaler,
//   and are freed on a collision hit or after passing the top row.
//
// Ports
//   clk       system clock
//   reset     synchronous active-high reset (highest priority)
//   clr       synchronous soft clear, same effect as reset
//   enable    gameplay enable; low freezes prescaler, cooldown and positions
//   shoot     fire button level (launch on rising edge only)
//   hit       per-slot hit from collision logic
//   posH      ship column
//   flying    per-slot active flags
//   bullet_x  packed slot columns, slot i at [i*X_W +: X_W]
//   bullet_y  packed slot rows,    slot i at [i*Y_W +: Y_W]
//   fired     one-cycle pulse the cycle after a launch is accepted
//   full      all slots flying
//   step      one-cycle movement tick pulse
// -----------------------------------------------------------------------------
module bullet_pool #(
  parameter int N_BULLETS = 4,
  parameter int X_W       = 5,
  parameter int Y_W       = 4,
  parameter int Y_START   = 14,
  parameter int STEP_DIV  = 8,
  parameter int COOLDOWN  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     enable,
  input  logic                     shoot,
  input  logic [N_BULLETS-1:0]     hit,
  input  logic [X_W-1:0]           posH,
  output logic [N_BULLETS-1:0]     flying,
  output logic [N_BULLETS*X_W-1:0] bullet_x,
  output logic [N_BULLETS*Y_W-1:0] bullet_y,
  output logic                     fired,
  output logic                     full,
  output logic                     step
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int SEL_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CD_W-1:0]  CD_INIT  = CD_W'(COOLDOWN);
  localparam logic [Y_W-1:0]   Y_INIT   = Y_W'(Y_START);

  logic                     shoot_q;
  logic [CNT_W-1:0]         cnt;
  logic [CD_W-1:0]          cd;

  logic                     rise;
  logic                     tick;
  logic                     launch;
  logic [SEL_W-1:0]         sel;

  logic [CNT_W-1:0]         cnt_n;
  logic [CD_W-1:0]          cd_n;
  logic [N_BULLETS-1:0]     flying_n;
  logic [N_BULLETS*X_W-1:0] x_n;
  logic [N_BULLETS*Y_W-1:0] y_n;

  // Lowest-index idle slot; scanning downward lets the lowest index win.
  function automatic logic [SEL_W-1:0] first_free(input logic [N_BULLETS-1:0] f);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!f[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  assign rise   = shoot & ~shoot_q;
  assign tick   = enable & (cnt == CNT_LAST);
  // Slot choice uses the current flags, so a slot freed this cycle is not
  // reusable until the next one.
  assign launch = rise & enable & (cd == '0) & ~full;
  assign sel    = first_free(flying);

  always_comb begin
    cnt_n    = cnt;
    cd_n     = cd;
    flying_n = flying;
    x_n      = bullet_x;
    y_n      = bullet_y;

    if (enable) begin
      cnt_n = tick ? '0 : cnt + 1'b1;
    end

    if (launch) begin
      cd_n = CD_INIT;
    end else if (tick && (cd != '0)) begin
      cd_n = cd - 1'b1;
    end

    // Hit beats movement; hits are honoured even while frozen.
    for (int i = 0; i < N_BULLETS; i++) begin
      if (flying[i]) begin
        if (hit[i]) begin
          flying_n[i] = 1'b0;
        end else if (tick) begin
          if (bullet_y[i*Y_W +: Y_W] != '0) begin
            y_n[i*Y_W +: Y_W] = bullet_y[i*Y_W +: Y_W] - 1'b1;
          end else begin
            flying_n[i] = 1'b0;
          end
        end
      end
    end

    // The launched slot is idle now, so neither hit nor movement touched it.
    if (launch) begin
      for (int i = 0; i < N_BULLETS; i++) begin
        if (SEL_W'(i) == sel) begin
          flying_n[i]       = 1'b1;
          x_n[i*X_W +: X_W] = posH;
          y_n[i*Y_W +: Y_W] = Y_INIT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      shoot_q  <= 1'b0;
      cnt      <= '0;
      cd       <= '0;
      flying   <= '0;
      bullet_x <= '0;
      bullet_y <= '0;
      fired    <= 1'b0;
      full     <= 1'b0;
      step     <= 1'b0;
    end else begin
      shoot_q  <= shoot;
      cnt      <= cnt_n;
      cd       <= cd_n;
      flying   <= flying_n;
      bullet_x <= x_n;
      bullet_y <= y_n;
      fired    <= launch;
      full     <= &flying_n;
      step     <= tick;
    end
  end

endmodule

// File: tb/tb_bullet_pool.sv
// -----------------------------------------------------------------------------
// tb_bullet_pool
//   Directed bench for bullet_pool with default parameters
//   (4 slots, X_W=5, Y_W=4, Y_START=14, STEP_DIV=8, COOLDOWN=2).
// -----------------------------------------------------------------------------
module tb_bullet_pool;

  localparam int N  = 4;
  localparam int XW = 5;
  localparam int YW = 4;

  logic            clk = 1'b0;
  logic            reset, clr, enable, shoot;
  logic [N-1:0]    hit;
  logic [XW-1:0]   posH;
  logic [N-1:0]    flying;
  logic [N*XW-1:0] bullet_x;
  logic [N*YW-1:0] bullet_y;
  logic            fired, full, step;

  int n_cmp = 0;
  int n_err = 0;

  bullet_pool dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .enable   (enable),
    .shoot    (shoot),
    .hit      (hit),
    .posH     (posH),
    .flying   (flying),
    .bullet_x (bullet_x),
    .bullet_y (bullet_y),
    .fired    (fired),
    .full     (full),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [YW-1:0] yof(input int i);
    return bullet_y[i*YW +: YW];
  endfunction

  function automatic logic [XW-1:0] xof(input int i);
    return bullet_x[i*XW +: XW];
  endfunction

  // Advance until a step pulse is visible; n = cycles taken.
  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 100);
    chk("step_wait", (n < 100), 1);
  endtask

  int n, steps;

  initial begin
    reset = 1'b1; clr = 1'b0; enable = 1'b0; shoot = 1'b0;
    hit = '0; posH = '0;

    // Reset
    cyc(); cyc();
    chk("rst_flying", flying, 0);
    chk("rst_x", bullet_x, 0);
    chk("rst_y", bullet_y, 0);
    chk("rst_fired", fired, 0);
    chk("rst_full", full, 0);
    chk("rst_step", step, 0);
    reset = 1'b0;
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (step) steps++;
    end
    chk("disabled_step", steps, 0);

    // Single launch and full climb
    enable = 1'b1; posH = 5'd10;
    cyc();
    shoot = 1'b1;
    cyc();
    chk("l0_fired", fired, 1);
    chk("l0_flying", flying, 4'b0001);
    chk("l0_x", xof(0), 10);
    chk("l0_y", yof(0), 14);
    cyc();
    chk("l0_fired_pulse", fired, 0);
    for (int k = 1; k <= 15; k++) begin
      wait_step(n);
      if (k == 1)  chk("climb_y1", yof(0), 13);
      if (k == 7)  chk("climb_y7", yof(0), 7);
      if (k == 14) begin
        chk("climb_y14", yof(0), 0);
        chk("climb_fly14", flying, 4'b0001);
      end
      if (k == 15) chk("climb_free15", flying, 4'b0000);
    end
    chk("autofire", fired, 0);

    // Cooldown
    shoot = 1'b0; posH = 5'd3;
    cyc();
    shoot = 1'b1;
    cyc();
    chk("cd_first_fired", fired, 1);
    chk("cd_first_x", xof(0), 3);
    shoot = 1'b0;
    cyc(); cyc();
    shoot = 1'b1;
    cyc();
    chk("cd_block_fired", fired, 0);
    chk("cd_block_flying", flying, 4'b0001);

    shoot = 1'b0;
    wait_step(n); wait_step(n);
    posH = 5'd20; shoot = 1'b1;
    cyc();
    chk("s1_fired", fired, 1);
    chk("s1_flying", flying, 4'b0011);
    chk("s1_x", xof(1), 20);
    chk("s1_y", yof(1), 14);

    // Fill the pool
    shoot = 1'b0;
    wait_step(n); wait_step(n);
    posH = 5'd7; shoot = 1'b1;
    cyc();
    chk("s2_flying", flying, 4'b0111);
    chk("s2_full", full, 0);
    shoot = 1'b0;
    wait_step(n); wait_step(n);
    posH = 5'd31; shoot = 1'b1;
    cyc();
    chk("s3_fired", fired, 1);
    chk("s3_flying", flying, 4'b1111);
    chk("s3_full", full, 1);
    chk("s3_x_all", bullet_x, {5'd31, 5'd7, 5'd20, 5'd3});
    shoot = 1'b0;
    wait_step(n); wait_step(n);
    posH = 5'd1; shoot = 1'b1;
    cyc();
    chk("full_fired", fired, 0);
    chk("full_flying", flying, 4'b1111);

    // Hits
    hit = 4'b0010;
    cyc();
    hit = 4'b0000;
    chk("hit1_flying", flying, 4'b1101);
    chk("hit1_full", full, 0);
    chk("hit1_y_all", bullet_y, {4'd12, 4'd10, 4'd8, 4'd6});
    wait_step(n);
    chk("move_after_hit", bullet_y, {4'd11, 4'd9, 4'd8, 4'd5});
    shoot = 1'b0; hit = 4'b0010;
    cyc();
    chk("hit_idle", flying, 4'b1101);
    posH = 5'd12; shoot = 1'b1; hit = 4'b0010;
    cyc();
    hit = 4'b0000;
    chk("hit_launch_fired", fired, 1);
    chk("hit_launch_flying", flying, 4'b1111);
    chk("hit_launch_x1", xof(1), 12);
    chk("hit_launch_y1", yof(1), 14);

    // Freeze
    shoot = 1'b0; enable = 1'b0;
    steps = 0;
    for (int i = 0; i < 50; i++) begin
      hit = (i == 20) ? 4'b0001 : 4'b0000;
      cyc();
      if (step) steps++;
    end
    hit = 4'b0000;
    chk("freeze_steps", steps, 0);
    chk("freeze_hit", flying, 4'b1110);
    chk("freeze_y", bullet_y, {4'd11, 4'd9, 4'd14, 4'd5});
    enable = 1'b1;
    wait_step(n);
    chk("prescaler_held", n, 6);
    chk("resume_y", bullet_y, {4'd10, 4'd8, 4'd13, 4'd5});

    // Soft clear mid-flight
    cyc();
    shoot = 1'b1; clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("clr_flying", flying, 0);
    chk("clr_fired", fired, 0);
    chk("clr_full", full, 0);
    chk("clr_xy", {bullet_x, bullet_y}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
